// File: rtl/sn_stream_decoder_if.sv
// Handshake/result bundle between an SN bitstream source/consumer and sn_stream_decoder.
interface sn_stream_decoder_if #(parameter int WINDOW_LOG2 = 4);
  logic                   start;
  logic                   sn_bit;
  logic                   sn_valid;
  logic                   out_ready;
  logic                   clr_ovr;
  logic                   busy;
  logic                   out_valid;
  logic [WINDOW_LOG2:0]   count;
  logic [WINDOW_LOG2+1:0] value;
  logic                   overrun;

  modport master (output start, sn_bit, sn_valid, out_ready, clr_ovr,
                  input  busy, out_valid, count, value, overrun);
  modport slave  (input  start, sn_bit, sn_valid, out_ready, clr_ovr,
                  output busy, out_valid, count, value, overrun);
endinterface

// File: rtl/sn_stream_decoder.sv
// SN stream decoder: counts 1s over N=2**WINDOW_LOG2 accepted bits, emits unipolar count and
// bipolar value 2*count-N. Define SN_DEC_CONTINUOUS_EN to re-arm windows back to back without start.
module sn_stream_decoder #(
  parameter int WINDOW_LOG2 = 4
) (
  input  logic clk,
  input  logic rst_n,
  sn_stream_decoder_if.slave bus
);
  localparam int W = WINDOW_LOG2;
  localparam int N = 1 << W;

  typedef enum logic [1:0] {IDLE, ACCUM, STALL} state_t;

`ifdef SN_DEC_CONTINUOUS_EN
  localparam state_t DONE_STATE = ACCUM;
`else
  localparam state_t DONE_STATE = IDLE;
`endif

  state_t       state;
  logic [W-1:0] bit_cnt;
  logic [W:0]   ones, ones_nxt, count_q;
  logic [W+1:0] value_q;
  logic         out_valid_q, overrun_q;
  logic         last, free;

  // ones is one bit wider than bit_cnt so an all-ones window reaches N without wrapping
  function automatic logic [W+1:0] bipolar(input logic [W:0] o);
    return {o, 1'b0} - (W+2)'(N);
  endfunction

  assign ones_nxt = ones + (W+1)'(bus.sn_bit);
  assign last     = (bit_cnt == W'(N-1));
  assign free     = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      ones        <= '0;
      count_q     <= '0;
      value_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // a consumed result drops valid unless a new result is loaded below
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

      if (state == STALL && bus.sn_valid) overrun_q <= 1'b1;
      else if (bus.clr_ovr)               overrun_q <= 1'b0;

      unique case (state)
        IDLE: if (bus.start) begin
          state   <= ACCUM;
          bit_cnt <= '0;
          ones    <= '0;
        end
        ACCUM: if (bus.sn_valid) begin
          if (last) begin
            bit_cnt <= '0;
            if (free) begin
              count_q     <= ones_nxt;
              value_q     <= bipolar(ones_nxt);
              out_valid_q <= 1'b1;
              ones        <= '0;
              state       <= DONE_STATE;
            end else begin
              ones  <= ones_nxt;
              state <= STALL;
            end
          end else begin
            bit_cnt <= bit_cnt + W'(1);
            ones    <= ones_nxt;
          end
        end
        STALL: if (out_valid_q && bus.out_ready) begin
          count_q     <= ones;
          value_q     <= bipolar(ones);
          out_valid_q <= 1'b1;
          ones        <= '0;
          state       <= DONE_STATE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.count     = count_q;
  assign bus.value     = value_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_sn_stream_decoder.sv
// Directed + randomized bench for sn_stream_decoder (N=16); expected results from bit popcounts.
module tb_sn_stream_decoder;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  sn_stream_decoder_if #(.WINDOW_LOG2(4)) bus();

  sn_stream_decoder #(.WINDOW_LOG2(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // bipolar reference: 2*ones - 16 in 6-bit two's complement
  function automatic logic [31:0] exp_val(input int ones);
    logic [5:0] v;
    v = 6'(2 * ones - 16);
    return 32'(v);
  endfunction

  task automatic begin_window();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // presents bits[0..15] with random idle gaps carrying junk sn_bit values
  task automatic send_window(input logic [15:0] bits, input int gap_max, input bit chk_pre);
    int g;
    for (int i = 0; i < 16; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        bus.sn_valid = 1'b0;
        bus.sn_bit   = 1'($urandom);
        step();
      end
      if (i == 15 && chk_pre) check("no_early_valid", 32'(bus.out_valid), 0);
      bus.sn_valid = 1'b1;
      bus.sn_bit   = bits[i];
      step();
    end
    bus.sn_valid = 1'b0;
    bus.sn_bit   = 1'b0;
  endtask

  task automatic check_result(input string tag, input int ones);
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_count"}, 32'(bus.count), 32'(ones));
    check({tag, "_value"}, 32'(bus.value), exp_val(ones));
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_drop"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    logic [15:0] bits, bits_a, bits_b;
    int          held;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.sn_bit = 1'b0; bus.sn_valid = 1'b0;
    bus.out_ready = 1'b0; bus.clr_ovr = 1'b0;

    // reset
    step(); step();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_value", 32'(bus.value), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    rst_n = 1'b1;

    // sn_valid in IDLE and in the start cycle must not be counted
    bus.sn_valid = 1'b1; bus.sn_bit = 1'b1;
    step(); step();
    check("idle_no_ovr", 32'(bus.overrun), 0);
    check("idle_busy", 32'(bus.busy), 0);
    begin_window();
    bus.sn_valid = 1'b0;
    check("start_busy", 32'(bus.busy), 1);
    send_window(16'hFFFF, 0, 1'b1);
    check_result("all_ones", 16);
`ifdef SN_DEC_CONTINUOUS_EN
    check("all_ones_busy", 32'(bus.busy), 1);
`else
    check("all_ones_busy", 32'(bus.busy), 0);
`endif
    consume("all_ones");
    check("hold_count", 32'(bus.count), 16);

    // alternating bits with random gaps
    begin_window();
    send_window(16'h5555, 3, 1'b1);
    check_result("alt", 8);
    consume("alt");

    // random windows vs popcount model
    for (int k = 0; k < 6; k++) begin
      bits = 16'($urandom);
      begin_window();
      send_window(bits, 2, 1'b1);
      check_result("rand", $countones(bits));
      consume("rand");
    end

    // back-pressure: result held stable
    begin_window();
    send_window(16'h1111, 1, 1'b1);
    repeat (5) begin
      check_result("hold", 4);
      step();
    end
    consume("hold");

    // window completes while previous result unread -> STALL, overrun
    bits_a = 16'($urandom);
    bits_b = 16'($urandom);
    begin_window();
    send_window(bits_a, 1, 1'b1);
    begin_window();
    send_window(bits_b, 1, 1'b0);
    check("stall_busy", 32'(bus.busy), 1);
    check_result("stall_a", $countones(bits_a));
    check("stall_no_ovr", 32'(bus.overrun), 0);
    bus.sn_valid = 1'b1; bus.sn_bit = 1'b1;
    repeat (3) step();
    bus.clr_ovr = 1'b1;
    step();
    bus.sn_valid = 1'b0; bus.clr_ovr = 1'b0;
    check("ovr_set_wins", 32'(bus.overrun), 1);
    check("stall_busy2", 32'(bus.busy), 1);
    check("stall_count_a", 32'(bus.count), 32'($countones(bits_a)));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_result("stall_b", $countones(bits_b));
`ifdef SN_DEC_CONTINUOUS_EN
    check("post_stall_busy", 32'(bus.busy), 1);
`else
    check("post_stall_busy", 32'(bus.busy), 0);
`endif
    check("ovr_sticky", 32'(bus.overrun), 1);
    bus.clr_ovr = 1'b1;
    step();
    bus.clr_ovr = 1'b0;
    check("ovr_clr", 32'(bus.overrun), 0);
    held = $countones(bits_b);
    check("stall_b_hold", 32'(bus.count), 32'(held));
    consume("stall_b");

    // reset mid-window discards partial window
    begin_window();
    bus.sn_valid = 1'b1; bus.sn_bit = 1'b1;
    repeat (7) step();
    bus.sn_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_count", 32'(bus.count), 0);
    begin_window();
    send_window(16'h0000, 1, 1'b1);
    check_result("zeros", 0);
    consume("zeros");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
